// File: rtl/mem_controller_m1_pkg.sv
// Types_m1: types shared by the M1 data-memory controller and its request queue.
//   mem_mode_e     - request kind from the LSU (read, write, fence, fence.i)
//   mem_rd_type_e  - read formatting selector carried in the fnc field
//   mem_req_t      - packed request-queue entry
//   memctl_state_e - controller FSM states
package Types_m1;

  typedef enum logic [1:0] {
    MODE_READ    = 2'd0,
    MODE_WRITE   = 2'd1,
    MODE_FENCE   = 2'd2,
    MODE_FENCE_I = 2'd3
  } mem_mode_e;

  typedef enum logic [1:0] {
    RD_WORD  = 2'd0,
    RD_SBYTE = 2'd1,
    RD_UBYTE = 2'd2,
    RD_WORD3 = 2'd3
  } mem_rd_type_e;

  typedef struct packed {
    mem_mode_e   mode;
    logic [14:0] addr;
    logic [1:0]  mask;
    logic [1:0]  fnc;
    logic [15:0] data;
    logic [3:0]  dest;
  } mem_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } memctl_state_e;

endpackage

// File: rtl/mem_controller_m1_queue.sv
// MemReqQueue_m1: in-order request FIFO for the M1 memory controller.
// Ports:
//   clk, async_rst_n  clock / asynchronous active-low reset
//   clk_en            state advances only when high
//   push, push_data   enqueue at tail (ignored when full)
//   pop               dequeue head (ignored when empty)
//   head              entry at the head of the queue
//   count             registered occupancy (0..DEPTH)
//   full, empty       derived from count
module MemReqQueue_m1
  import Types_m1::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     clk_en,
  input  logic                     push,
  input  mem_req_t                 push_data,
  input  logic                     pop,
  output mem_req_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  mem_req_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && clk_en;
  assign do_pop  = pop && !empty && clk_en;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_controller_m1.sv
// mem_controller_m1: data-memory controller behind the M1 LSU.
// Buffers read/write/fence requests in an in-order queue, issues one
// transaction at a time on a single-port SRAM-style bus and returns formatted
// read data with its writeback destination through a hold-until-ready handshake.
// Ports:
//   clk, async_rst_n, clk_en            clock, async active-low reset, global enable
//   mem_*_in, mem_enable_in             request from the core
//   mem_input_ready                     core accepts read data
//   mem_data_out, mem_wb_dest_out,
//   mem_read_ack                        read result (held until ready)
//   mem_available, mem_idle             queue status
//   icache_flush                        pulse when a fence.i is retired
//   bus_req/we/addr/be/wdata, bus_ack/rdata   backing bus
// Optional feature: define MEMCTL_M1_PERF_EN to add perf_reads, perf_writes
// and perf_stall_cycles counters.
module mem_controller_m1
  import Types_m1::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic [14:0] mem_address_in,
  input  logic [1:0]  mem_mask_in,
  input  logic [1:0]  mem_read_fnc_type_in,
  input  logic [15:0] mem_data_in,
  input  logic [1:0]  mem_mode_in,
  input  logic        mem_enable_in,
  input  logic [3:0]  mem_wb_dest_in,
  input  logic        mem_input_ready,
  output logic [15:0] mem_data_out,
  output logic [3:0]  mem_wb_dest_out,
  output logic        mem_read_ack,
  output logic        mem_available,
  output logic        mem_idle,
  output logic        icache_flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [14:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
`ifdef MEMCTL_M1_PERF_EN
  output logic [15:0] perf_reads,
  output logic [15:0] perf_writes,
  output logic [15:0] perf_stall_cycles,
`endif
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  memctl_state_e state, next_state;
  mem_req_t      push_req;
  mem_req_t      head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_pop;
  logic          load_resp;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_fmt;
  logic [15:0]   resp_data_q;
  logic [3:0]    resp_dest_q;

  assign push_req = '{mode: mem_mode_e'(mem_mode_in), addr: mem_address_in,
                      mask: mem_mask_in, fnc: mem_read_fnc_type_in,
                      data: mem_data_in, dest: mem_wb_dest_in};
  assign q_push   = mem_enable_in && mem_available;

  MemReqQueue_m1 #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .push        (q_push),
    .push_data   (push_req),
    .pop         (q_pop),
    .head        (head),
    .count       (q_count),
    .full        (q_full),
    .empty       (q_empty)
  );

  assign mem_available   = !q_full;
  assign mem_idle        = q_empty && (state == ST_IDLE);
  assign mem_read_ack    = (state == ST_RESP);
  assign mem_data_out    = resp_data_q;
  assign mem_wb_dest_out = resp_dest_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) state <= ST_IDLE;
    else if (clk_en)  state <= next_state;
  end

  // Bus outputs come straight from the head entry, which cannot change until
  // the ack pops it, so they are stable for the whole transaction.
  always_comb begin
    next_state   = state;
    q_pop        = 1'b0;
    load_resp    = 1'b0;
    icache_flush = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_be       = '0;
    bus_wdata    = '0;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          if (head.mode == MODE_READ || head.mode == MODE_WRITE) begin
            bus_req    = 1'b1;
            bus_we     = (head.mode == MODE_WRITE);
            bus_addr   = head.addr;
            bus_be     = head.mask;
            bus_wdata  = head.data;
            next_state = ST_BUS;
          end else begin
            // Serial controller: everything older is already complete.
            q_pop        = 1'b1;
            icache_flush = (head.mode == MODE_FENCE_I) && clk_en;
          end
        end
      end
      ST_BUS: begin
        bus_req   = 1'b1;
        bus_we    = (head.mode == MODE_WRITE);
        bus_addr  = head.addr;
        bus_be    = head.mask;
        bus_wdata = head.data;
        if (bus_ack) begin
          q_pop = 1'b1;
          if (head.mode == MODE_READ) begin
            load_resp  = 1'b1;
            next_state = ST_RESP;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_RESP: begin
        if (mem_input_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_byte = (head.mask == 2'b10) ? bus_rdata[15:8] : bus_rdata[7:0];
    case (mem_rd_type_e'(head.fnc))
      RD_SBYTE: rd_fmt = {{8{rd_byte[7]}}, rd_byte};
      RD_UBYTE: rd_fmt = {8'h00, rd_byte};
      default:  rd_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      resp_data_q <= '0;
      resp_dest_q <= '0;
    end else if (clk_en && load_resp) begin
      resp_data_q <= rd_fmt;
      resp_dest_q <= head.dest;
    end
  end

`ifdef MEMCTL_M1_PERF_EN
  logic bus_done;
  assign bus_done = clk_en && (state == ST_BUS) && bus_ack;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      perf_reads        <= '0;
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (bus_done && head.mode == MODE_READ)  perf_reads  <= perf_reads + 16'd1;
      if (bus_done && head.mode == MODE_WRITE) perf_writes <= perf_writes + 16'd1;
      if (clk_en && state == ST_BUS && !bus_ack)
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_controller_m1.sv
module tb_mem_controller_m1;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic [14:0] mem_address_in;
  logic [1:0]  mem_mask_in;
  logic [1:0]  mem_read_fnc_type_in;
  logic [15:0] mem_data_in;
  logic [1:0]  mem_mode_in;
  logic        mem_enable_in;
  logic [3:0]  mem_wb_dest_in;
  logic        mem_input_ready;
  logic [15:0] mem_data_out;
  logic [3:0]  mem_wb_dest_out;
  logic        mem_read_ack;
  logic        mem_available;
  logic        mem_idle;
  logic        icache_flush;
  logic        bus_req;
  logic        bus_we;
  logic [14:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  mem_controller_m1 #(.QUEUE_DEPTH(4)) dut (
    .clk                  (clk),
    .async_rst_n          (async_rst_n),
    .clk_en               (clk_en),
    .mem_address_in       (mem_address_in),
    .mem_mask_in          (mem_mask_in),
    .mem_read_fnc_type_in (mem_read_fnc_type_in),
    .mem_data_in          (mem_data_in),
    .mem_mode_in          (mem_mode_in),
    .mem_enable_in        (mem_enable_in),
    .mem_wb_dest_in       (mem_wb_dest_in),
    .mem_input_ready      (mem_input_ready),
    .mem_data_out         (mem_data_out),
    .mem_wb_dest_out      (mem_wb_dest_out),
    .mem_read_ack         (mem_read_ack),
    .mem_available        (mem_available),
    .mem_idle             (mem_idle),
    .icache_flush         (icache_flush),
    .bus_req              (bus_req),
    .bus_we               (bus_we),
    .bus_addr             (bus_addr),
    .bus_be               (bus_be),
    .bus_wdata            (bus_wdata),
    .bus_ack              (bus_ack),
    .bus_rdata            (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [1:0] mode, input logic [14:0] addr, input logic [1:0] mask,
                         input logic [1:0] fnc, input logic [15:0] data, input logic [3:0] dest);
    mem_mode_in          = mode;
    mem_address_in       = addr;
    mem_mask_in          = mask;
    mem_read_fnc_type_in = fnc;
    mem_data_in          = data;
    mem_wb_dest_in       = dest;
    mem_enable_in        = 1'b1;
  endtask

  task automatic push(input logic [1:0] mode, input logic [14:0] addr, input logic [1:0] mask,
                      input logic [1:0] fnc, input logic [15:0] data, input logic [3:0] dest);
    set_req(mode, addr, mask, fnc, data, dest);
    tick();
    mem_enable_in = 1'b0;
  endtask

  // Read with a one-wait-free bus: IDLE(req) -> BUS(ack) -> RESP -> IDLE.
  task automatic do_read(input string tag, input logic [14:0] addr, input logic [1:0] mask,
                         input logic [1:0] fnc, input logic [3:0] dest,
                         input logic [15:0] rdata, input logic [15:0] exp);
    bus_rdata = rdata;
    push(2'd0, addr, mask, fnc, 16'h0000, dest);
    chk({tag, "_req"}, bus_req, 1'b1);
    chk({tag, "_we"}, bus_we, 1'b0);
    chk({tag, "_addr"}, bus_addr, addr);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk({tag, "_ack"}, mem_read_ack, 1'b1);
    chk({tag, "_data"}, mem_data_out, exp);
    chk({tag, "_dest"}, mem_wb_dest_out, dest);
    mem_input_ready = 1'b1;
    tick();
    mem_input_ready = 1'b0;
    chk({tag, "_ackclr"}, mem_read_ack, 1'b0);
    chk({tag, "_idle"}, mem_idle, 1'b1);
  endtask

  initial begin
    async_rst_n          = 1'b0;
    clk_en               = 1'b1;
    mem_address_in       = '0;
    mem_mask_in          = '0;
    mem_read_fnc_type_in = '0;
    mem_data_in          = '0;
    mem_mode_in          = '0;
    mem_enable_in        = 1'b0;
    mem_wb_dest_in       = '0;
    mem_input_ready      = 1'b0;
    bus_ack              = 1'b0;
    bus_rdata            = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_avail", mem_available, 1'b1);
    chk("rst_idle", mem_idle, 1'b1);
    chk("rst_read_ack", mem_read_ack, 1'b0);
    chk("rst_flush", icache_flush, 1'b0);
    chk("rst_data", mem_data_out, 16'h0000);
    chk("rst_wdata", bus_wdata, 16'h0000);
    async_rst_n = 1'b1;
    tick();

    // Write, ack after two BUS cycles: bus held for three cycles
    push(2'd1, 15'h0123, 2'b11, 2'd0, 16'hBEEF, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("wr_req", bus_req, 1'b1);
      chk("wr_we", bus_we, 1'b1);
      chk("wr_be", bus_be, 2'b11);
      chk("wr_wdata", bus_wdata, 16'hBEEF);
      chk("wr_addr", bus_addr, 15'h0123);
      chk("wr_busy", mem_idle, 1'b0);
      if (i == 2) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    chk("wr_done_req", bus_req, 1'b0);
    chk("wr_done_idle", mem_idle, 1'b1);

    // Zero-mask write still goes to the bus with be=0
    push(2'd1, 15'h0042, 2'b00, 2'd0, 16'h1234, 4'd0);
    chk("wr0_req", bus_req, 1'b1);
    chk("wr0_be", bus_be, 2'b00);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("wr0_idle", mem_idle, 1'b1);

    // Signed-byte read of the high byte, result held while core not ready
    bus_rdata = 16'h80AA;
    push(2'd0, 15'h0050, 2'b10, 2'd1, 16'h0000, 4'd5);
    chk("sb_req", bus_req, 1'b1);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sb_ack_hold", mem_read_ack, 1'b1);
      chk("sb_data", mem_data_out, 16'hFF80);
      chk("sb_dest", mem_wb_dest_out, 4'd5);
      tick();
    end
    mem_input_ready = 1'b1;
    chk("sb_ack_at_ready", mem_read_ack, 1'b1);
    tick();
    mem_input_ready = 1'b0;
    chk("sb_ack_clr", mem_read_ack, 1'b0);

    // Read formatting vectors
    do_read("ub_lo",   15'h0100, 2'b01, 2'd2, 4'd3, 16'h80AA, 16'h00AA);
    do_read("ub_hi",   15'h0101, 2'b10, 2'd2, 4'd7, 16'h80AA, 16'h0080);
    do_read("word",    15'h0102, 2'b11, 2'd0, 4'd9, 16'h80AA, 16'h80AA);
    do_read("word3",   15'h0103, 2'b10, 2'd3, 4'd1, 16'h1234, 16'h1234);
    do_read("sb_pos",  15'h0104, 2'b11, 2'd1, 4'd2, 16'h127F, 16'h007F);
    do_read("sb_m0",   15'h0105, 2'b00, 2'd1, 4'd15, 16'hAAFE, 16'hFFFE);

    // Queue full: four accepted, fifth dropped, drained in order
    bus_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(2'd1, 15'(16'h0010 + i), 2'b11, 2'd0, 16'(16'h1000 + i), 4'd0);
      tick();
      if (i < 3) chk("qf_avail_hi", mem_available, 1'b1);
      else       chk("qf_avail_lo", mem_available, 1'b0);
    end
    mem_enable_in = 1'b0;
    chk("qf_head0", bus_addr, 15'h0010);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("qf_avail_after_pop", mem_available, 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk("qf_order_req", bus_req, 1'b1);
      chk("qf_order_addr", bus_addr, 15'(16'h0010 + i));
      chk("qf_order_wdata", bus_wdata, 16'(16'h1000 + i));
      tick();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
    end
    chk("qf_drop_req", bus_req, 1'b0);
    chk("qf_drop_idle", mem_idle, 1'b1);

    // Fence.i between a write and a read
    set_req(2'd1, 15'h0200, 2'b11, 2'd0, 16'h5555, 4'd0);
    tick();
    chk("fi_wr_req", bus_req, 1'b1);
    chk("fi_flush0", icache_flush, 1'b0);
    set_req(2'd3, 15'h0000, 2'b00, 2'd3, 16'h0000, 4'd0);
    tick();
    chk("fi_flush1", icache_flush, 1'b0);
    set_req(2'd0, 15'h0300, 2'b11, 2'd0, 16'h0000, 4'd4);
    tick();
    mem_enable_in = 1'b0;
    chk("fi_flush2", icache_flush, 1'b0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("fi_flush_pulse", icache_flush, 1'b1);
    chk("fi_no_req", bus_req, 1'b0);
    tick();
    chk("fi_flush_end", icache_flush, 1'b0);
    chk("fi_rd_req", bus_req, 1'b1);
    chk("fi_rd_addr", bus_addr, 15'h0300);
    tick();
    bus_rdata = 16'hCAFE;
    bus_ack   = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("fi_rd_data", mem_data_out, 16'hCAFE);
    mem_input_ready = 1'b1;
    tick();
    mem_input_ready = 1'b0;

    // Fence type 2: popped, no side effect
    push(2'd2, 15'h0000, 2'b00, 2'd2, 16'h0000, 4'd0);
    chk("f2_flush", icache_flush, 1'b0);
    chk("f2_req", bus_req, 1'b0);
    tick();
    chk("f2_idle", mem_idle, 1'b1);

    // clk_en low freezes ack sampling
    push(2'd1, 15'h0400, 2'b01, 2'd0, 16'h00FF, 4'd0);
    tick();
    clk_en  = 1'b0;
    bus_ack = 1'b1;
    tick();
    chk("ce_frozen_req", bus_req, 1'b1);
    chk("ce_frozen_avail", mem_available, 1'b1);
    clk_en = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("ce_done_req", bus_req, 1'b0);
    chk("ce_done_idle", mem_idle, 1'b1);

    // Async reset mid-BUS drops the request immediately
    push(2'd1, 15'h0555, 2'b11, 2'd0, 16'hAAAA, 4'd0);
    tick();
    chk("rb_req_before", bus_req, 1'b1);
    async_rst_n = 1'b0;
    #1;
    chk("rb_req_dropped", bus_req, 1'b0);
    chk("rb_idle", mem_idle, 1'b1);
    chk("rb_avail", mem_available, 1'b1);
    async_rst_n = 1'b1;
    tick();

    // Async reset discards a held read result
    bus_rdata = 16'h4321;
    push(2'd0, 15'h0600, 2'b11, 2'd0, 16'h0000, 4'd6);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("rr_ack_before", mem_read_ack, 1'b1);
    async_rst_n = 1'b0;
    #1;
    chk("rr_ack_dropped", mem_read_ack, 1'b0);
    chk("rr_data_cleared", mem_data_out, 16'h0000);
    async_rst_n = 1'b1;
    tick();
    chk("rr_idle_after", mem_idle, 1'b1);
    chk("rr_avail_after", mem_available, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_controller_m1.md
# mem_controller_m1

- Data-memory controller directly downstream of the M1 core's LSU memory interface.
- Accepts read, write and fence requests through the core's `mem_*` port and buffers them in an in-order request queue.
- Issues one transaction at a time to a single-port SRAM-style backing bus.
- Returns formatted read data, with its writeback destination, through a hold-until-ready handshake.

## Interface

Parameters:
- `QUEUE_DEPTH`, 4: request queue entries; power of two, ≥2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock.
- `async_rst_n`  in  1  asynchronous active-low reset.
- `clk_en`  in  1  global clock enable; all state advances only when high.
- `mem_address_in`  in  15  word address.
- `mem_mask_in`  in  2  byte enables; bit0 = low byte, bit1 = high byte.
- `mem_read_fnc_type_in`  in  2
  - On read: 0 word, 1 signed byte, 2 unsigned byte, 3 treated as word.
  - On fence: fence type.
- `mem_data_in`  in  16  store data.
- `mem_mode_in`  in  2  0 read, 1 write, 2/3 fence.
- `mem_enable_in`  in  1  request valid.
- `mem_wb_dest_in`  in  4  read destination register.
- `mem_input_ready`  in  1  core accepts read data.
- `mem_data_out`  out  16  read result.
- `mem_wb_dest_out`  out  4  destination of `mem_data_out`.
- `mem_read_ack`  out  1  read result valid.
- `mem_available`  out  1  queue can accept a request.
- `mem_idle`  out  1  queue empty, FSM in IDLE.
- `icache_flush`  out  1  one-cycle pulse on a type-3 fence.
- `bus_req`  out  1  backend request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  15  backend address.
- `bus_be`  out  2  backend byte enables.
- `bus_wdata`  out  16  backend write data.
- `bus_ack`  in  1  single-cycle completion; `bus_rdata` is valid with it.
- `bus_rdata`  in  16  backend read data.

## Operation

- **Push:** `mem_enable_in && mem_available && clk_en` writes {mode, addr, mask, fnc, data, dest} at the queue tail.
  - A request while `mem_available` is low is dropped; the core must not issue one.
- **`mem_available`:** `count != QUEUE_DEPTH`, computed from registered count.
  - A pop does not free a slot until the next cycle.
- **FSM states:** IDLE, BUS, RESP.
- **IDLE, head is read/write:** drive `bus_*` from the head entry, assert `bus_req`, go to BUS.
- **IDLE, head is fence:** pop it and stay in IDLE.
  - Mode 3 also pulses `icache_flush` for that cycle.
  - Fence type 2 has no side effect.
  - Because the controller is strictly serial, all older operations are already complete when a fence reaches the head.
- **BUS:** `bus_*` is held stable until `bus_ack`.
  - On ack, the head is popped.
  - Write: go to IDLE.
  - Read: latch the formatted data and dest, go to RESP.
- **RESP:** `mem_read_ack` is high with data and dest held.
  - When `mem_input_ready` is sampled high, go to IDLE.
- **Read formatting:**
  - Word: `bus_rdata` unchanged.
  - Byte: select the high byte iff `mask == 2'b10`, otherwise the low byte.
  - Signed byte: sign-extend to 16 bits. Unsigned byte: zero-extend.
- **Writes:** `bus_be` = mask, `bus_wdata` = data unchanged.
  - A mask of 0 still issues the bus transaction with `be = 0`.
- **Simultaneous push and pop:** count unchanged, both pointers advance.
  - Pointers wrap modulo `QUEUE_DEPTH`.
- **`mem_idle`:** `count == 0 && state == IDLE`.

## Timing

- **Reset values:**
  - All outputs are 0 except `mem_available = 1` and `mem_idle = 1`.
  - Queue empty, FSM in IDLE.
- **Reset mid-operation:** clears immediately (async).
  - `bus_req` drops without waiting for ack; the backend must tolerate the abandoned request.
  - A held read result is discarded.
- **Latency:**
  - Request accepted at cycle N → `bus_req` at N+1 at the earliest.
  - `bus_ack` at cycle M → `mem_read_ack` at M+1.
  - Best-case read from request to `mem_read_ack`: 3 cycles with a 1-cycle bus.
- **Throughput:** back-to-back writes with zero-wait ack take 2 cycles each (IDLE→BUS→IDLE).
- **`clk_en` low:** freezes all state, including `bus_ack` sampling; the backend shares the enable domain.

## Configuration

- **Macro:** `MEMCTL_M1_PERF_EN`.
- **With the macro defined:**
  - Adds outputs `perf_reads` [15:0], `perf_writes` [15:0] and `perf_stall_cycles` [15:0].
  - Counters wrap, reset to 0, and count popped reads, popped writes, and BUS-state cycles without ack.
- **Without the macro:** the ports and the logic are absent.

## Structure

- **Shared package `Types_m1`:**
  - `mem_mode_e` (READ, WRITE, FENCE, FENCE_I).
  - `mem_rd_type_e`.
  - Packed `mem_req_t` queue entry.
  - `memctl_state_e`.
- **Sub-module:** `MemReqQueue_m1`, a parameterised synchronous FIFO with push, pop, head, count, full and empty.
- The FSM and read formatting live in the top level.

## Test plan

- **Reset:** assert `async_rst_n` low mid-BUS → `bus_req` drops at once; after release `mem_idle = 1` and `mem_available = 1`.
- **Write:**
  - Stimulus: write addr 0x0123, mask 2'b11, data 0xBEEF; ack after 2 cycles.
  - Expect: `bus_we = 1`, `bus_be = 3`, `bus_wdata = 0xBEEF` held 3 cycles; `mem_idle` returns 1.
- **Signed-byte read:**
  - Stimulus: mask 2'b10, dest 5, `bus_rdata = 0x80AA`.
  - Expect: `mem_data_out = 0xFF80`, `mem_wb_dest_out = 5`, `mem_read_ack` held while `mem_input_ready = 0` for 4 cycles, cleared the cycle after ready.
- **Unsigned-byte read:** mask 2'b01, rdata 0x80AA → 0x00AA.
- **Queue full:** 5 pushes with `bus_ack` held low → `mem_available` low after the 4th; the queue drains in order; `mem_available` rises the cycle after the first pop.
- **Fence:**
  - Stimulus: write, fence mode 3, read queued.
  - Expect: `icache_flush` pulses one cycle, strictly after the write's ack and before the read's `bus_req`.
